// File: rtl/fb_writer.sv
// Frame-buffer writer: packs a valid/ready byte stream into 16-bit pixels and
// writes them sequentially into BRAM port A, optionally starting on VGA vsync.
module fb_writer #(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int BASE_ADDR  = 0,
    parameter int WAIT_VSYNC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_vs,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        wea,
    output logic [14:0] addra,
    output logic [15:0] dina,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [14:0] LAST_CNT = 15'(IMG_W * IMG_H - 1);
    localparam logic [14:0] BASE     = 15'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        LOAD_HI = 3'd2,
        LOAD_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic        wea_q, wea_d;
    logic [14:0] addra_q, addra_d;
    logic [15:0] dina_q, dina_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        vs_s1_q, vs_s2_q, vs_prev_q;
    logic        vs_fall_s;
    logic        hs_s;

    // The handshake uses the registered ready, so s_ready never depends on s_valid.
    assign hs_s      = s_valid & ready_q;
    assign vs_fall_s = vs_prev_q & ~vs_s2_q;

    // Vsync synchroniser and edge register; idle level of VS is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            vs_s1_q   <= i_vs;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    // Next-state, pixel packing and write-port register inputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        case (state_q)
            IDLE: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_start) begin
                    cnt_d   = 15'd0;
                    state_d = (WAIT_VSYNC != 0) ? WAIT_VS : LOAD_HI;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_VS: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (vs_fall_s) begin
                    state_d = LOAD_HI;
                end else begin
                    state_d = WAIT_VS;
                end
            end
            LOAD_HI: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (hs_s) begin
                    hi_d    = s_data;
                    state_d = LOAD_LO;
                end else begin
                    state_d = LOAD_HI;
                end
            end
            LOAD_LO: begin
                // An abort in this cycle drops the half pixel instead of writing it.
                if (i_abort) begin
                    state_d = IDLE;
                end else if (hs_s) begin
                    wea_d   = 1'b1;
                    addra_d = BASE + cnt_q;
                    dina_d  = {hi_q, s_data};
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 15'd1;
                        state_d = LOAD_HI;
                    end
                end else begin
                    state_d = LOAD_LO;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they align with the state register.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            WAIT_VS: begin
                busy_d = 1'b1;
            end
            LOAD_HI, LOAD_LO: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 15'd0;
            hi_q    <= 8'd0;
            wea_q   <= 1'b0;
            addra_q <= 15'd0;
            dina_q  <= 16'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_ready = ready_q;
    assign wea     = wea_q;
    assign addra   = addra_q;
    assign dina    = dina_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: three instances cover immediate start,
// vsync-gated start with abort/restart, and a non-zero base address.
module tb_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_abort;
    logic        i_vs;
    logic        s_valid;
    logic [7:0]  s_data;
    logic [2:0]  start;
    logic [2:0]  rdy, wea, busy, done;
    logic [14:0] addr [3];
    logic [15:0] din  [3];

    int checks   = 0;
    int failures = 0;
    logic [30:0] wq0[$], wq1[$], wq2[$];
    int dcnt [3] = '{default: 0};
    int dwea [3] = '{default: 0};

    always #5 clk = ~clk;

    fb_writer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(0), .WAIT_VSYNC(0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_abort(i_abort), .i_vs(i_vs),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]), .wea(wea[0]),
        .addra(addr[0]), .dina(din[0]), .o_busy(busy[0]), .o_done(done[0]));

    fb_writer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(0), .WAIT_VSYNC(1)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_abort(i_abort), .i_vs(i_vs),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]), .wea(wea[1]),
        .addra(addr[1]), .dina(din[1]), .o_busy(busy[1]), .o_done(done[1]));

    fb_writer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(100), .WAIT_VSYNC(0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_abort(i_abort), .i_vs(i_vs),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[2]), .wea(wea[2]),
        .addra(addr[2]), .dina(din[2]), .o_busy(busy[2]), .o_done(done[2]));

    // Record every BRAM write and every done pulse, away from the active edge.
    always @(negedge clk) begin
        if (wea[0]) wq0.push_back({addr[0], din[0]});
        if (wea[1]) wq1.push_back({addr[1], din[1]});
        if (wea[2]) wq2.push_back({addr[2], din[2]});
        for (int k = 0; k < 3; k++) begin
            if (done[k]) dcnt[k]++;
            if (done[k] && wea[k]) dwea[k]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return wq0.size();
            1:       return wq1.size();
            default: return wq2.size();
        endcase
    endfunction

    function automatic logic [30:0] wentry(input int k, input int i);
        case (k)
            0:       return (i < wq0.size()) ? wq0[i] : 31'd0;
            1:       return (i < wq1.size()) ? wq1[i] : 31'd0;
            default: return (i < wq2.size()) ? wq2[i] : 31'd0;
        endcase
    endfunction

    // Offer one byte until the instance shows ready before an edge (bounded).
    task automatic send(input int k, input logic [7:0] b);
        bit acc;
        acc     = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int t = 0; t < 40 && !acc; t++) begin
            acc = rdy[k];
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic stream(input int k, input logic [7:0] first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send(k, first + 8'(i));
            if (gap > 0 && i < n - 1) cyc(gap);
        end
    endtask

    task automatic check_writes(input int k, input int b, input int n,
                                input logic [14:0] a0, input logic [7:0] d0);
        chk("wr_count", 32'(qsize(k) - b), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("wr%0d_%0d", k, i), 32'(wentry(k, b + i)),
                32'({a0 + 15'(i), d0 + 8'(2 * i), d0 + 8'(2 * i + 1)}));
        end
    endtask

    initial begin
        int b;
        int d;
        int lat;
        bit seen;
        rst_n   = 1'b0;
        start   = 3'b000;
        i_abort = 1'b0;
        i_vs    = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        cyc(3);
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(addr[0]), 32'd0);
        chk("rst_din", 32'(din[0]), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Continuous stream, immediate start
        b = qsize(0); d = dcnt[0];
        start[0] = 1'b1; cyc(1); start[0] = 1'b0;
        chk("t1_ready_on", 32'(rdy[0]), 32'd1);
        chk("t1_busy_on", 32'(busy[0]), 32'd1);
        stream(0, 8'h00, 15, 0);
        send(0, 8'h0F);
        chk("t1_last_wea", 32'(wea[0]), 32'd1);
        chk("t1_last_done", 32'(done[0]), 32'd1);
        chk("t1_last_addr", 32'(addr[0]), 32'd7);
        chk("t1_last_din", 32'(din[0]), 32'h0E0F);
        chk("t1_busy_off", 32'(busy[0]), 32'd0);
        chk("t1_ready_off", 32'(rdy[0]), 32'd0);
        cyc(3);
        check_writes(0, b, 8, 15'd0, 8'h00);
        chk("t1_done_cnt", 32'(dcnt[0] - d), 32'd1);
        chk("t1_ready_after", 32'(rdy[0]), 32'd0);
        chk("t1_addr_hold", 32'(addr[0]), 32'd7);

        // Valid toggling every other cycle
        b = qsize(0); d = dcnt[0];
        start[0] = 1'b1; cyc(1); start[0] = 1'b0;
        stream(0, 8'h00, 16, 1);
        cyc(3);
        check_writes(0, b, 8, 15'd0, 8'h00);
        chk("t2_done_cnt", 32'(dcnt[0] - d), 32'd1);
        chk("t2_done_wea", 32'(dwea[0]), 32'd2);

        // Vsync-gated start
        start[1] = 1'b1; cyc(1); start[1] = 1'b0;
        chk("t3_busy_wait", 32'(busy[1]), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rdy[1]) seen = 1'b1;
            cyc(1);
        end
        chk("t3_ready_held", 32'(seen), 32'd0);
        i_vs = 1'b0;
        lat  = 0;
        while (!rdy[1] && lat < 10) begin
            cyc(1);
            lat++;
        end
        chk("t3_vs_latency", 32'(lat), 32'd3);

        // Abort after three bytes, then restart
        b = qsize(1); d = dcnt[1];
        send(1, 8'hA0);
        send(1, 8'hA1);
        send(1, 8'hA2);
        i_abort = 1'b1; cyc(1); i_abort = 1'b0;
        chk("t4_abort_busy", 32'(busy[1]), 32'd0);
        chk("t4_abort_ready", 32'(rdy[1]), 32'd0);
        cyc(5);
        chk("t4_abort_writes", 32'(qsize(1) - b), 32'd1);
        chk("t4_abort_wr0", 32'(wentry(1, b)), 32'({15'd0, 16'hA0A1}));
        chk("t4_abort_done", 32'(dcnt[1] - d), 32'd0);
        i_vs = 1'b1;
        cyc(4);
        start[1] = 1'b1; cyc(1); start[1] = 1'b0;
        chk("t4_restart_wait", 32'(rdy[1]), 32'd0);
        i_vs = 1'b0;
        cyc(3);
        chk("t4_restart_ready", 32'(rdy[1]), 32'd1);
        b = qsize(1); d = dcnt[1];
        stream(1, 8'h50, 16, 0);
        cyc(3);
        check_writes(1, b, 8, 15'd0, 8'h50);
        chk("t4_done_cnt", 32'(dcnt[1] - d), 32'd1);

        // Non-zero base address, start pulsed mid-load
        b = qsize(2); d = dcnt[2];
        start[2] = 1'b1; cyc(1); start[2] = 1'b0;
        stream(2, 8'h80, 6, 0);
        start[2] = 1'b1; cyc(1); start[2] = 1'b0;
        stream(2, 8'h86, 10, 0);
        cyc(3);
        check_writes(2, b, 8, 15'd100, 8'h80);
        chk("t5_done_cnt", 32'(dcnt[2] - d), 32'd1);

        // Asynchronous reset while a write is on the port
        start[0] = 1'b1; cyc(1); start[0] = 1'b0;
        send(0, 8'h11);
        send(0, 8'h22);
        chk("t6_pre_wea", 32'(wea[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_wea", 32'(wea[0]), 32'd0);
        chk("t6_rst_ready", 32'(rdy[0]), 32'd0);
        chk("t6_rst_busy", 32'(busy[0]), 32'd0);
        chk("t6_rst_addr", 32'(addr[0]), 32'd0);
        #3 rst_n = 1'b1;
        cyc(3);
        chk("t6_idle_ready", 32'(rdy[0]), 32'd0);
        chk("t6_idle_busy", 32'(busy[0]), 32'd0);
        chk("t6_idle_wea", 32'(wea[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
# fb_writer

Frame-buffer writer that fills the 16-bit cover-art/graphics BRAM read by the VGA display path (port B: 15-bit `addrb`, 16-bit `doutb`). It accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit pixels and writes them sequentially through BRAM port A. It sits between the SD/MP3 data source and the dual-port image RAM. Loads can optionally be held until vertical sync so a new image starts during blanking.

## Interface
Parameters:
- `IMG_W`, 160, image width in pixels
- `IMG_H`, 120, image height in pixels; `IMG_W*IMG_H` must be ≤ 32768 − `BASE_ADDR`
- `BASE_ADDR`, 0, first BRAM word address written
- `WAIT_VSYNC`, 1, 1 = start load on first VS falling edge after start; 0 = start immediately

Ports:
- `clk`  in  1  system clock (100 MHz)
- `rst_n`  in  1  reset; asynchronous, active-low
- `i_start`  in  1  single-cycle request to load one image
- `i_abort`  in  1  cancel current load
- `i_vs`  in  1  VGA vertical sync (active-low, pixel-clock domain; synchronised internally)
- `s_data`  in  8  stream byte
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  block accepts a byte this cycle
- `wea`  out  1  BRAM port A write enable
- `addra`  out  15  BRAM port A address
- `dina`  out  16  BRAM port A write data
- `o_busy`  out  1  load in progress (WAIT_VS, LOAD_HI or LOAD_LO)
- `o_done`  out  1  one-cycle pulse when last pixel written

## Operation
- States: IDLE, WAIT_VS, LOAD_HI, LOAD_LO, DONE.
- IDLE: `s_ready`=0. `i_start` → WAIT_VS if `WAIT_VSYNC`=1, else LOAD_HI; pixel counter cleared to 0.
- WAIT_VS: `i_vs` through 2-flop synchroniser plus edge register; on synchronised 1→0 transition → LOAD_HI.
- LOAD_HI: `s_ready`=1; on `s_valid&&s_ready` latch byte as `dina[15:8]` → LOAD_LO.
- LOAD_LO: `s_ready`=1; on handshake register write: `dina`={hi,byte}, `addra`=`BASE_ADDR`+count, `wea`=1 for the following cycle. If count = `IMG_W*IMG_H`−1 → DONE, else count+1 → LOAD_HI.
- DONE: `o_done`=1 for exactly one cycle, `s_ready`=0, → IDLE.
- Byte order: first byte of each pair is the high byte. No handshake → state holds.
- `i_start` outside IDLE ignored. `i_abort` in any non-IDLE state → IDLE next cycle, no `o_done`, pending half-pixel discarded; a write already registered (`wea`=1 this cycle) completes. `i_abort` and `i_start` same cycle in IDLE: abort wins, stays IDLE.
- Counter width 15 bits; never wraps: terminal count ends the load, further bytes are not accepted.

## Timing
- Reset values: `s_ready`=0, `wea`=0, `addra`=0, `dina`=0, `o_busy`=0, `o_done`=0, state IDLE, synchroniser flops=1 (VS idle high).
- `s_ready` is a registered function of state only (no combinational path from `s_valid`).
- Low-byte accept in cycle N → `wea`=1 with valid `addra`/`dina` in cycle N+1; `addra`/`dina` hold afterwards until next write.
- Max throughput: one byte per clock, one pixel write per two clocks; next high byte may be accepted in the same cycle `wea`=1.
- Last low byte accepted in cycle N → `wea`=1 and `o_done`=1 both in cycle N+1; `o_busy`=0 from N+1.
- WAIT_VS → LOAD_HI latency: 3 `clk` cycles after `i_vs` falls (2 sync + edge detect), `s_ready`=1 on the following cycle.
- Asynchronous reset mid-load: all outputs to reset values immediately; image in BRAM left partially written.

## Test plan
- `WAIT_VSYNC`=0, `IMG_W`=4,`IMG_H`=2: start, stream bytes 0x00..0x0F with `s_valid` continuous → 8 writes, addr 0..7, data 0x0001,0x0203…0x0E0F; `o_done` once with last write; `s_ready`=0 after.
- Same, `s_valid` toggling 1/0 every cycle → identical write sequence, no duplicated or dropped bytes.
- `WAIT_VSYNC`=1: start with `i_vs`=1 held 50 cycles → `s_ready` stays 0; drop `i_vs` → `s_ready`=1 within 4 cycles.
- Abort after 3 bytes (one write done) → IDLE, no second write, no `o_done`; restart → first write again at `BASE_ADDR` with new data.
- `BASE_ADDR`=100: 8-pixel load → addresses 100..107; `i_start` pulsed mid-load → ignored, count unaffected.
- Assert `rst_n`=0 mid-load (async, between clock edges) → `wea`,`s_ready`,`o_busy` drop to 0 before next edge; after release state IDLE.
